// File: rtl/serial_link_bringup_seq.sv
// Bring-up sequencer for the serial link: drives the register-bus cfg port through
// the fixed link-start sequence (resets, allocator config, settle, de-isolation, poll).
module serial_link_bringup_seq #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter logic [31:0] CtrlOffset     = 32'h0,
  parameter logic [31:0] AllocTxOffset  = 32'h0,
  parameter logic [31:0] AllocRxOffset  = 32'h0,
  parameter logic [31:0] IsolatedOffset = 32'h0,
  parameter int unsigned SettleCycles   = 50,
  parameter int unsigned MaxPolls       = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [3:0]             err_step_o,
  output logic                   cfg_valid_o,
  output logic                   cfg_write_o,
  output logic [AddrWidth-1:0]   cfg_addr_o,
  output logic [DataWidth-1:0]   cfg_wdata_o,
  output logic [DataWidth/8-1:0] cfg_wstrb_o,
  input  logic [DataWidth-1:0]   cfg_rdata_i,
  input  logic                   cfg_error_i,
  input  logic                   cfg_ready_i
);

  localparam int unsigned SettleW = $clog2(SettleCycles + 1);
  localparam int unsigned PollW   = $clog2(MaxPolls + 1);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SettleCycles - 1);
  localparam logic [PollW-1:0]   PollLast   = PollW'(MaxPolls - 1);
  localparam logic [PollW-1:0]   PollSat    = PollW'(MaxPolls);

  localparam logic [3:0] STEP_ALLOC_RX = 4'd4;
  localparam logic [3:0] STEP_SETTLE   = 4'd5;
  localparam logic [3:0] STEP_DEISO    = 4'd6;
  localparam logic [3:0] STEP_POLL     = 4'd7;
  localparam logic [3:0] STEP_TIMEOUT  = 4'd8;

  typedef enum logic [2:0] {
    IDLE, REQ, GAP, SETTLE, DONE, ERROR
  } state_t;

  state_t               state;
  logic [3:0]           step;
  logic [SettleW-1:0]   settle_cnt;
  logic [PollW-1:0]     poll_cnt;

  logic [3:0]           issue_step;
  logic                 issue_write;
  logic [AddrWidth-1:0] issue_addr;
  logic [DataWidth-1:0] issue_wdata;

  // Request about to be launched: step 0 from an idle state, step 6 when settle ends,
  // otherwise the step already advanced during the idle gap cycle.
  always_comb begin
    issue_step  = 4'd0;
    issue_write = 1'b1;
    issue_addr  = AddrWidth'(CtrlOffset);
    issue_wdata = '0;
    if (state == GAP) begin
      issue_step = step;
    end else if (state == SETTLE) begin
      issue_step = STEP_DEISO;
    end
    case (issue_step)
      4'd0: issue_wdata = DataWidth'(32'h300);
      4'd1: issue_wdata = DataWidth'(32'h302);
      4'd2: issue_wdata = DataWidth'(32'h303);
      4'd3: begin
        issue_addr  = AddrWidth'(AllocTxOffset);
        issue_wdata = DataWidth'(32'h3);
      end
      4'd4: begin
        issue_addr  = AddrWidth'(AllocRxOffset);
        issue_wdata = DataWidth'(32'h3);
      end
      4'd6: issue_wdata = DataWidth'(32'h3);
      4'd7: begin
        issue_write = 1'b0;
        issue_addr  = AddrWidth'(IsolatedOffset);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      step        <= '0;
      settle_cnt  <= '0;
      poll_cnt    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      err_step_o  <= '0;
      cfg_valid_o <= 1'b0;
      cfg_write_o <= 1'b0;
      cfg_addr_o  <= '0;
      cfg_wdata_o <= '0;
      cfg_wstrb_o <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            state       <= REQ;
            step        <= '0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            err_step_o  <= '0;
            cfg_valid_o <= 1'b1;
            cfg_write_o <= issue_write;
            cfg_addr_o  <= issue_addr;
            cfg_wdata_o <= issue_wdata;
            cfg_wstrb_o <= '1;
          end
        end
        REQ: begin
          if (cfg_valid_o && cfg_ready_i) begin
            cfg_valid_o <= 1'b0;
            if (cfg_error_i) begin
              state      <= ERROR;
              busy_o     <= 1'b0;
              error_o    <= 1'b1;
              err_step_o <= step;
            end else if (step < STEP_ALLOC_RX) begin
              step  <= step + 4'd1;
              state <= GAP;
            end else if (step == STEP_ALLOC_RX) begin
              step       <= STEP_SETTLE;
              settle_cnt <= SettleLoad;
              state      <= SETTLE;
            end else if (step == STEP_DEISO) begin
              step     <= STEP_POLL;
              poll_cnt <= '0;
              state    <= GAP;
            end else if (cfg_rdata_i == '0) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else if (poll_cnt == PollLast) begin
              // Link never left isolation within the poll budget.
              state      <= ERROR;
              busy_o     <= 1'b0;
              error_o    <= 1'b1;
              err_step_o <= STEP_TIMEOUT;
            end else begin
              if (poll_cnt != PollSat) begin
                poll_cnt <= poll_cnt + PollW'(1);
              end
              state <= GAP;
            end
          end
        end
        GAP: begin
          state       <= REQ;
          cfg_valid_o <= 1'b1;
          cfg_write_o <= issue_write;
          cfg_addr_o  <= issue_addr;
          cfg_wdata_o <= issue_wdata;
          cfg_wstrb_o <= '1;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state       <= REQ;
            step        <= STEP_DEISO;
            cfg_valid_o <= 1'b1;
            cfg_write_o <= issue_write;
            cfg_addr_o  <= issue_addr;
            cfg_wdata_o <= issue_wdata;
            cfg_wstrb_o <= '1;
          end else begin
            settle_cnt <= settle_cnt - SettleW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          busy_o      <= 1'b0;
          cfg_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_bringup_seq.sv
// Directed bench for serial_link_bringup_seq: a scripted register-bus slave logs every
// access, and a scenario table plus hand-written reset/restart sequences check the log.
module tb_serial_link_bringup_seq;

  localparam logic [31:0] CTRL   = 32'h0000_0100;
  localparam logic [31:0] TX     = 32'h0000_0200;
  localparam logic [31:0] RX     = 32'h0000_0204;
  localparam logic [31:0] ISO    = 32'h0000_0108;
  localparam int          SETTLE = 50;
  localparam int          MAXP   = 4;
  localparam int          BOUND  = 3000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, error_o;
  logic [3:0]  err_step_o;
  logic        cfg_valid_o, cfg_write_o;
  logic [31:0] cfg_addr_o, cfg_wdata_o;
  logic [3:0]  cfg_wstrb_o;
  logic [31:0] cfg_rdata_i = '0;
  logic        cfg_error_i = 1'b0;
  logic        cfg_ready_i = 1'b0;

  serial_link_bringup_seq #(
    .AddrWidth(32), .DataWidth(32),
    .CtrlOffset(CTRL), .AllocTxOffset(TX), .AllocRxOffset(RX), .IsolatedOffset(ISO),
    .SettleCycles(SETTLE), .MaxPolls(MAXP)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_step_o(err_step_o),
    .cfg_valid_o(cfg_valid_o), .cfg_write_o(cfg_write_o), .cfg_addr_o(cfg_addr_o),
    .cfg_wdata_o(cfg_wdata_o), .cfg_wstrb_o(cfg_wstrb_o), .cfg_rdata_i(cfg_rdata_i),
    .cfg_error_i(cfg_error_i), .cfg_ready_i(cfg_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          start_cyc;
    int          end_cyc;
  } access_t;

  typedef struct {
    string      name;
    int         wait_n;
    bit         ready_idle;
    int         err_at;
    int         nonzero_reads;
    bit         stuck;
    int         exp_reads;
    bit         exp_done;
    bit         exp_error;
    logic [3:0] exp_err_step;
  } scen_t;

  access_t log_q[$];
  access_t exp_tab[6];
  scen_t   scen[6];

  int checks = 0;
  int fails = 0;

  // Slave configuration, written only by the stimulus side.
  int wait_n = 0;
  bit ready_idle = 1'b0;
  int err_at = -1;
  int nonzero_reads = 0;
  bit stuck = 1'b0;
  int log_base = 0;
  int poll_base = 0;
  int stable_base = 0;

  // Slave state, written only by the slave process.
  int          cycle = 0;
  int          reads_given = 0;
  int          stable_errs = 0;
  bit          in_req = 1'b0;
  int          cur_wait = 0;
  int          req_start = 0;
  logic        held_write;
  logic [31:0] held_addr, held_wdata;

  // Register-bus slave: answers after wait_n stall cycles and checks request stability.
  always @(negedge clk_i) begin
    cycle++;
    if (!rst_ni || !cfg_valid_o) begin
      in_req      = 1'b0;
      cur_wait    = 0;
      cfg_ready_i = rst_ni ? ready_idle : 1'b0;
      cfg_error_i = 1'b0;
      cfg_rdata_i = '0;
    end else begin
      if (in_req && (cfg_addr_o != held_addr || cfg_wdata_o != held_wdata ||
                     cfg_write_o != held_write)) stable_errs++;
      if (!in_req) begin
        in_req    = 1'b1;
        req_start = cycle;
        cur_wait  = 0;
      end
      held_write = cfg_write_o;
      held_addr  = cfg_addr_o;
      held_wdata = cfg_wdata_o;
      if (cur_wait >= wait_n) begin
        cfg_ready_i = 1'b1;
        cfg_error_i = (err_at == log_q.size() - log_base);
        cfg_rdata_i = '0;
        if (!cfg_write_o) begin
          if (reads_given - poll_base < nonzero_reads)
            cfg_rdata_i = (reads_given == poll_base) ? 32'h3 : 32'h1;
          else
            cfg_rdata_i = stuck ? 32'h3 : 32'h0;
          reads_given++;
        end
        log_q.push_back('{cfg_write_o, cfg_addr_o, cfg_wdata_o, req_start, cycle});
        in_req = 1'b0;
      end else begin
        cfg_ready_i = 1'b0;
        cfg_error_i = 1'b0;
        cur_wait++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pulseStart();
    @(negedge clk_i) start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy_o && n < BOUND) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput({tag, " busy drops within bound"}, 64'(n < BOUND), 64'd1);
    repeat (5) @(negedge clk_i);
  endtask

  // Compare the logged accesses since log_base against the fixed link-start order.
  task automatic checkAccesses(input string tag, input int exp_n);
    int got_n = log_q.size() - log_base;
    int gap_viol = 0;
    checkOutput({tag, " access count"}, 64'(got_n), 64'(exp_n));
    for (int i = 0; i < exp_n && i < got_n; i++) begin
      access_t a = log_q[log_base + i];
      access_t e;
      if (i < 6) e = exp_tab[i];
      else e = '{1'b0, ISO, 32'h0, 0, 0};
      checkOutput($sformatf("%s access %0d addr", tag, i), 64'(a.addr), 64'(e.addr));
      checkOutput($sformatf("%s access %0d write/wdata", tag, i),
                  {31'b0, a.write, (a.write ? a.wdata : 32'h0)},
                  {31'b0, e.write, e.wdata});
    end
    for (int i = 0; i + 1 < got_n; i++)
      if (log_q[log_base + i + 1].start_cyc - log_q[log_base + i].end_cyc < 2) gap_viol++;
    checkOutput({tag, " idle cycle between requests"}, 64'(gap_viol), 64'd0);
    if (exp_n >= 6 && got_n >= 6) begin
      int gap = log_q[log_base + 5].start_cyc - log_q[log_base + 4].end_cyc - 1;
      checkOutput({tag, " settle gap >= SettleCycles"}, 64'(gap >= SETTLE), 64'd1);
    end
    checkOutput({tag, " request stable while stalled"},
                64'(stable_errs - stable_base), 64'd0);
  endtask

  task automatic configSlave(input int w, input bit ri, input int ea, input int nz,
                             input bit st);
    wait_n        = w;
    ready_idle    = ri;
    err_at        = ea;
    nonzero_reads = nz;
    stuck         = st;
    log_base      = log_q.size();
    poll_base     = reads_given;
    stable_base   = stable_errs;
  endtask

  task automatic applyStimulus(input scen_t s);
    int exp_n;
    configSlave(s.wait_n, s.ready_idle, s.err_at, s.nonzero_reads, s.stuck);
    pulseStart();
    checkOutput({s.name, " flags after start"},
                {60'b0, busy_o, done_o, error_o, 1'b0}, {60'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    checkOutput({s.name, " err_step cleared on start"}, 64'(err_step_o), 64'd0);
    waitIdle(s.name);
    checkOutput({s.name, " done/error/busy"}, {61'b0, done_o, error_o, busy_o},
                {61'b0, s.exp_done, s.exp_error, 1'b0});
    checkOutput({s.name, " err_step"}, 64'(err_step_o), 64'(s.exp_err_step));
    exp_n = (s.err_at >= 0) ? s.err_at + 1 : 6 + s.exp_reads;
    checkAccesses(s.name, exp_n);
  endtask

  initial begin
    int n;
    exp_tab[0] = '{1'b1, CTRL, 32'h300, 0, 0};
    exp_tab[1] = '{1'b1, CTRL, 32'h302, 0, 0};
    exp_tab[2] = '{1'b1, CTRL, 32'h303, 0, 0};
    exp_tab[3] = '{1'b1, TX,   32'h3,   0, 0};
    exp_tab[4] = '{1'b1, RX,   32'h3,   0, 0};
    exp_tab[5] = '{1'b1, CTRL, 32'h3,   0, 0};

    scen[0] = '{"zero_wait", 0, 1'b1, -1, 0, 1'b0, 1, 1'b1, 1'b0, 4'd0};
    scen[1] = '{"wait3",     3, 1'b0, -1, 0, 1'b0, 1, 1'b1, 1'b0, 4'd0};
    scen[2] = '{"poll3",     0, 1'b1, -1, 2, 1'b0, 3, 1'b1, 1'b0, 4'd0};
    scen[3] = '{"timeout",   1, 1'b0, -1, 0, 1'b1, 4, 1'b0, 1'b1, 4'd8};
    scen[4] = '{"bus_err",   0, 1'b1,  3, 0, 1'b0, 0, 1'b0, 1'b1, 4'd3};
    scen[5] = '{"replay",    2, 1'b0, -1, 0, 1'b0, 1, 1'b1, 1'b0, 4'd0};

    #12;
    checkOutput("reset flags", {56'b0, busy_o, done_o, error_o, err_step_o, cfg_valid_o},
                64'd0);
    checkOutput("reset bus outputs", {27'b0, cfg_write_o, cfg_wstrb_o, cfg_addr_o | cfg_wdata_o},
                64'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 6; i++) applyStimulus(scen[i]);

    // Async reset while the step-2 write is stalled on the bus.
    configSlave(3, 1'b0, -1, 0, 1'b0);
    pulseStart();
    n = 0;
    while (!(cfg_valid_o && cfg_wdata_o == 32'h303) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("reset_mid step-2 request seen", 64'(n < 200), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("reset_mid flags drop", {56'b0, busy_o, done_o, error_o, err_step_o, cfg_valid_o},
                64'd0);
    checkOutput("reset_mid bus drops", {27'b0, cfg_write_o, cfg_wstrb_o, cfg_addr_o | cfg_wdata_o},
                64'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Restart after reset, with a second start pulse landing mid-sequence.
    configSlave(0, 1'b1, -1, 0, 1'b0);
    pulseStart();
    repeat (4) @(negedge clk_i);
    checkOutput("restart busy before extra start", 64'(busy_o), 64'd1);
    pulseStart();
    waitIdle("restart");
    checkOutput("restart done/error", {62'b0, done_o, error_o}, 64'b10);
    checkAccesses("restart", 7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_link_bringup_seq.md
Name: serial_link_bringup_seq

Overview:
Hardware bring-up sequencer for the serial link. It masters the link's register-bus configuration port and executes the fixed link-start sequence autonomously:
- reset/clock-enable writes
- channel-allocator config writes
- settle delay
- AXI de-isolation
- isolation-status poll

It sits directly upstream of the serial link's cfg port, in the register clock domain. Software or a boot FSM starts the sequence with one pulse.

Parameters:
AddrWidth, 32, register-bus address width
DataWidth, 32, register-bus data width (must be 32)
CtrlOffset, 32'h0, address of link CTRL register
AllocTxOffset, 32'h0, address of channel-allocator TX cfg register
AllocRxOffset, 32'h0, address of channel-allocator RX cfg register
IsolatedOffset, 32'h0, address of ISOLATED status register
SettleCycles, 50, idle cycles between allocator config and de-isolation (>=1)
MaxPolls, 1024, maximum ISOLATED reads before timeout (>=1)

Ports:
clk_i  in  1  register-domain clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  single-cycle pulse; starts sequence when not busy
busy_o  out  1  sequence in progress
done_o  out  1  sticky; sequence completed successfully
error_o  out  1  sticky; bus error or poll timeout
err_step_o  out  4  step index at which error occurred
cfg_valid_o  out  1  register request valid
cfg_write_o  out  1  1 = write, 0 = read
cfg_addr_o  out  AddrWidth  request address
cfg_wdata_o  out  DataWidth  write data
cfg_wstrb_o  out  DataWidth/8  write strobe, always all-ones
cfg_rdata_i  in  DataWidth  read data
cfg_error_i  in  1  response error, valid with ready
cfg_ready_i  in  1  request accepted/completed

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: state IDLE; all outputs 0, including cfg_* and err_step_o.
- All outputs are registered.

Steps (err_step_o code: action):
- 0: write CtrlOffset 32'h300
- 1: write CtrlOffset 32'h302
- 2: write CtrlOffset 32'h303
- 3: write AllocTxOffset 32'h3
- 4: write AllocRxOffset 32'h3
- 5: SETTLE, count SettleCycles cycles, no bus request
- 6: write CtrlOffset 32'h03
- 7: read IsolatedOffset; repeat until rdata == 0
- 8: timeout code

States:
- IDLE: start_i → REQ at step 0; clear done_o and error_o; set busy_o.
- REQ: cfg_valid_o=1 with addr/write/wdata held stable.
  - Completion is the cycle where cfg_valid_o & cfg_ready_i.
  - In the cycle after completion, cfg_valid_o = 0 (one idle bus cycle between requests).
- REQ completion with cfg_error_i=1: go to ERROR, err_step_o = current step.
- REQ completion of steps 0–3: REQ at next step.
- REQ completion of step 4: go to SETTLE.
- SETTLE: counter loads SettleCycles−1 and decrements each cycle. At 0 → REQ step 6.
- Step 6 completion: go to POLL, poll counter = 0.
- POLL (step 7 read):
  - On completion with rdata == 0: go to DONE.
  - On completion with rdata != 0: increment poll counter. If counter reaches MaxPolls, go to ERROR with err_step_o = 8. Otherwise issue the next read after one idle cycle.
- DONE: done_o=1, busy_o=0. start_i restarts from step 0.
- ERROR: error_o=1, busy_o=0. start_i restarts from step 0 and clears error_o and err_step_o.
- start_i while busy_o=1 is ignored.
- Async reset mid-transaction: cfg_valid_o drops immediately. There is no attempt to complete the pending access.
- Counters are sized $clog2(max+1). They saturate and never wrap.
- cfg_ready_i while cfg_valid_o=0 is ignored.
- cfg_ready_i in the same cycle that valid first rises is legal: zero-wait completion.

Test Plan:
1. Zero-wait slave (ready=1 always), ISOLATED reads 0 first time → exactly 6 writes, in order 0x300, 0x302, 0x303, 0x3 (TX), 0x3 (RX), 0x03 (CTRL). ≥SettleCycles=50 idle cycles between the RX write and the CTRL 0x03 write. One read. done_o=1, error_o=0.
2. Slave inserts 3 wait cycles per access → addr/wdata stable while valid and not ready. Same access sequence. done_o=1.
3. ISOLATED returns 0x3, 0x1, then 0x0 → exactly 3 reads, then done_o=1.
4. MaxPolls=4, ISOLATED always 0x3 → 4 reads, then error_o=1, err_step_o=8, busy_o=0, done_o=0.
5. cfg_error_i=1 on the AllocTx write → error_o=1, err_step_o=3. No further requests. A subsequent start_i replays from 0x300 and clears error_o.
6. rst_ni asserted during the step-2 request → all outputs 0 immediately. start_i after reset begins again at step 0. A start_i pulse while busy produces no restart or duplicate access.
